// File: rtl/spi_pkg.sv
// Shared constants for the 3-wire SPI responder: FSM encoding, bit-order codes
// and the bit-counter width helper.
package spi_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT    = 2'd1;
  localparam logic [1:0] ST_WORD_END = 2'd2;

  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned word_len);
    return $clog2(word_len + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous bus input, with an extra
// history flop giving one-clk rise/fall pulses on the synchronised level.
module spi_sync_edge #(
  parameter int unsigned Stages = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {Stages{RstVal}};
      prev  <= RstVal;
    end else begin
      chain <= {chain[Stages-2:0], din};
      prev  <= chain[Stages-1];
    end
  end

  assign q    = chain[Stages-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_3wire.sv
// SPI mode-0 responder for the 3-wire half-duplex bus (shared SDIO line).
// Optional status flags (StatusClr/TxUnderrun/FrameErr) under `SPI_SLAVE_STATUS_EN.
module spi_slave_3wire
  import spi_pkg::*;
#(
  parameter int unsigned WordLen    = 8,
  parameter int unsigned SyncStages = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SCLK,
  input  logic               CSn,
  inout  wire                SDIO,
  input  logic               TxMode,
  input  logic               Endiannes,
  input  logic [WordLen-1:0] TxData,
  input  logic               TxValid,
  output logic               TxReady,
  output logic [WordLen-1:0] RxData,
  output logic               RxValid,
  output logic               Busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic               StatusClr,
  output logic               TxUnderrun,
  output logic               FrameErr
`endif
);

  localparam int unsigned CntW = cnt_width(WordLen);

  logic sclk_unused, sclk_rise, sclk_fall;
  logic csn_s, csn_rise, csn_fall;
  logic [SyncStages-1:0] sdio_sync;
  logic sdio_s;

  logic [1:0]         state;
  logic [CntW-1:0]    bitcnt;
  logic [WordLen-1:0] rx_reg, tx_reg, hold;
  logic               hold_full, tx_mode_l, endian_l, reload_pend;
  logic               load, idle_consume, reload, consume, tx_bit, drive_en;

  spi_sync_edge #(.Stages(SyncStages), .RstVal(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(SCLK),
    .q(sclk_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // CSn idles high, so its synchroniser resets high to avoid a spurious frame.
  spi_sync_edge #(.Stages(SyncStages), .RstVal(1'b1)) u_csn_sync (
    .clk(clk), .rst(rst), .din(CSn),
    .q(csn_s), .rise(csn_rise), .fall(csn_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sdio_sync <= '0;
    else     sdio_sync <= {sdio_sync[SyncStages-2:0], SDIO};
  end
  assign sdio_s = sdio_sync[SyncStages-1];

  assign Busy    = ~csn_s;
  assign TxReady = ~hold_full;
  assign load    = TxValid & ~hold_full;

  assign idle_consume = (state == ST_IDLE) && csn_fall && TxMode && !csn_rise;
  assign reload       = (state == ST_SHIFT) && sclk_fall && tx_mode_l && reload_pend && !csn_rise;
  assign consume      = idle_consume | reload;

  // A load coinciding with a consume of an empty holding register is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (load) begin
      hold      <= TxData;
      hold_full <= 1'b1;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bitcnt      <= '0;
      rx_reg      <= '0;
      tx_reg      <= '0;
      tx_mode_l   <= 1'b0;
      endian_l    <= LSB_FIRST;
      reload_pend <= 1'b0;
      RxData      <= '0;
      RxValid     <= 1'b0;
    end else begin
      RxValid <= 1'b0;
      if (csn_rise) begin
        state       <= ST_IDLE;
        bitcnt      <= '0;
        tx_reg      <= '0;
        reload_pend <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (csn_fall) begin
              tx_mode_l   <= TxMode;
              endian_l    <= Endiannes;
              bitcnt      <= '0;
              reload_pend <= 1'b0;
              state       <= ST_SHIFT;
              if (TxMode) tx_reg <= hold_full ? hold : '0;
            end
          end
          ST_SHIFT: begin
            if (sclk_rise) begin
              if (!tx_mode_l) begin
                if (endian_l == MSB_FIRST) rx_reg <= {rx_reg[WordLen-2:0], sdio_s};
                else                       rx_reg <= {sdio_s, rx_reg[WordLen-1:1]};
              end
              bitcnt <= bitcnt + CntW'(1);
              if (bitcnt == CntW'(WordLen - 1)) state <= ST_WORD_END;
            end else if (sclk_fall && tx_mode_l) begin
              if (reload_pend) begin
                tx_reg      <= hold_full ? hold : '0;
                reload_pend <= 1'b0;
              end else if (bitcnt != '0) begin
                if (endian_l == MSB_FIRST) tx_reg <= {tx_reg[WordLen-2:0], 1'b0};
                else                       tx_reg <= {1'b0, tx_reg[WordLen-1:1]};
              end
            end
          end
          ST_WORD_END: begin
            if (!tx_mode_l) begin
              RxData  <= rx_reg;
              RxValid <= 1'b1;
            end
            bitcnt      <= '0;
            reload_pend <= tx_mode_l;
            state       <= ST_SHIFT;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_bit   = (endian_l == MSB_FIRST) ? tx_reg[WordLen-1] : tx_reg[0];
  assign drive_en = (state != ST_IDLE) && tx_mode_l && Busy;
  assign SDIO     = drive_en ? tx_bit : 1'bz;

`ifdef SPI_SLAVE_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TxUnderrun <= 1'b0;
      FrameErr   <= 1'b0;
    end else begin
      if (consume && !hold_full) TxUnderrun <= 1'b1;
      else if (StatusClr)        TxUnderrun <= 1'b0;
      if (csn_rise && (state != ST_IDLE) && (bitcnt != '0)) FrameErr <= 1'b1;
      else if (StatusClr)                                   FrameErr <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_3wire.sv
// Directed bench for spi_slave_3wire acting as a mode-0 SPI master on the 3-wire bus;
// a pull-up on SDIO makes a released line read as 1.
module tb_spi_slave_3wire;

  localparam int unsigned HALF = 6;

  logic       clk, rst, SCLK, CSn, TxMode, Endiannes, TxValid, TxReady, RxValid, Busy;
  logic [7:0] TxData, RxData;
  logic       sdio_oe, sdio_drv;
  wire        SDIO;
`ifdef SPI_SLAVE_STATUS_EN
  logic StatusClr, TxUnderrun, FrameErr;
`endif

  int total = 0;
  int bad   = 0;
  int rxv_cnt = 0;

  pullup (SDIO);
  assign SDIO = sdio_oe ? sdio_drv : 1'bz;

  spi_slave_3wire #(.WordLen(8), .SyncStages(2)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CSn(CSn), .SDIO(SDIO),
    .TxMode(TxMode), .Endiannes(Endiannes), .TxData(TxData), .TxValid(TxValid),
    .TxReady(TxReady), .RxData(RxData), .RxValid(RxValid), .Busy(Busy)
`ifdef SPI_SLAVE_STATUS_EN
    , .StatusClr(StatusClr), .TxUnderrun(TxUnderrun), .FrameErr(FrameErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (RxValid) rxv_cnt++;

  typedef struct {
    logic       tx;
    logic       msb;
    logic [7:0] data;    // RX: expected RxData;  TX: word loaded
    logic [7:0] stream;  // bus bit order, first bit at [7]; RX: driven, TX: expected
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] w);
    int unsigned n = 0;
    while (!TxReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!TxReady) begin
      total++;
      bad++;
      $display("FAIL load_timeout: actual TxReady=0 required=1");
    end
    TxData  = w;
    TxValid = 1'b1;
    @(negedge clk);
    TxValid = 1'b0;
  endtask

  task automatic frame_begin(input logic tx, input logic msb);
    TxMode    = tx;
    Endiannes = msb;
    sdio_oe   = ~tx;
    CSn       = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_bits(input int unsigned n, input logic [15:0] mosi, output logic [15:0] miso);
    miso = '0;
    for (int unsigned i = 0; i < n; i++) begin
      sdio_drv = mosi[n-1-i];
      repeat (HALF) @(negedge clk);
      miso[n-1-i] = SDIO;
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    CSn     = 1'b1;
    sdio_oe = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [15:0] got;
    logic [7:0]  last_rx;
    int          c0;

    rst = 1'b1; SCLK = 1'b0; CSn = 1'b1; TxMode = 1'b0; Endiannes = 1'b0;
    TxData = '0; TxValid = 1'b0; sdio_oe = 1'b0; sdio_drv = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    StatusClr = 1'b0;
`endif
    last_rx = 8'h00;

    vecs[0] = '{tx: 1'b0, msb: 1'b0, data: 8'hA5, stream: 8'b1010_0101};
    vecs[1] = '{tx: 1'b0, msb: 1'b1, data: 8'hD2, stream: 8'b1101_0010};
    vecs[2] = '{tx: 1'b0, msb: 1'b0, data: 8'h4B, stream: 8'b1101_0010};
    vecs[3] = '{tx: 1'b1, msb: 1'b1, data: 8'h3C, stream: 8'b0011_1100};
    vecs[4] = '{tx: 1'b1, msb: 1'b0, data: 8'hC1, stream: 8'b1000_0011};
    vecs[5] = '{tx: 1'b1, msb: 1'b1, data: 8'h96, stream: 8'b1001_0110};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_txready", TxReady, 1);
    check("reset_rxvalid", RxValid, 0);
    check("reset_rxdata",  RxData,  8'h00);
    check("reset_busy",    Busy,    0);
    check("reset_sdio_released", SDIO, 1);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].tx) load_word(vecs[i].data);
      c0 = rxv_cnt;
      frame_begin(vecs[i].tx, vecs[i].msb);
      if (vecs[i].tx) check("tx_txready_after_csn", TxReady, 1);
      shift_bits(8, {8'h00, vecs[i].stream}, got);
      frame_end();
      if (vecs[i].tx) begin
        check("tx_stream", got[7:0], vecs[i].stream);
        check("tx_no_rxvalid", rxv_cnt - c0, 0);
      end else begin
        check("rx_data", RxData, vecs[i].data);
        check("rx_valid_pulses", rxv_cnt - c0, 1);
        last_rx = vecs[i].data;
      end
      check("sdio_released_after_frame", SDIO, 1);
    end

    // Back-to-back transmit: 0x81 then 0x7E in one 16-bit frame, then a third word.
    load_word(8'h81);
    frame_begin(1'b1, 1'b1);
    check("b2b_busy", Busy, 1);
    check("b2b_txready_after_csn", TxReady, 1);
    load_word(8'h7E);
    check("b2b_txready_after_load2", TxReady, 0);
    shift_bits(16, 16'h0000, got);
    frame_end();
    check("b2b_stream", got, 16'h817E);
    check("b2b_txready_after_frame", TxReady, 1);
    load_word(8'h55);
    check("b2b_third_accepted", TxReady, 0);
    frame_begin(1'b1, 1'b0);
    shift_bits(8, 16'h0000, got);
    frame_end();
    check("b2b_third_stream_lsb", got[7:0], 8'hAA);

    // Abort after 5 bits: no RxValid, RxData unchanged, next frame good.
    c0 = rxv_cnt;
    frame_begin(1'b0, 1'b0);
    shift_bits(5, 16'h0016, got);
    frame_end();
    check("abort_no_rxvalid", rxv_cnt - c0, 0);
    check("abort_rxdata_kept", RxData, last_rx);
`ifdef SPI_SLAVE_STATUS_EN
    check("abort_frameerr", FrameErr, 1);
`endif
    c0 = rxv_cnt;
    frame_begin(1'b0, 1'b0);
    shift_bits(8, 16'h00F0, got);
    frame_end();
    check("after_abort_rxdata", RxData, 8'h0F);
    check("after_abort_rxvalid", rxv_cnt - c0, 1);

    // Reset during bit 3 of a transmit frame of 0xA3 (MSB first: 1,0,1,0,...).
    load_word(8'hA3);
    c0 = rxv_cnt;
    frame_begin(1'b1, 1'b1);
    shift_bits(3, 16'h0000, got);
    repeat (4) @(negedge clk);
    check("midrst_bit3_driven", SDIO, 0);
    rst = 1'b1;
    #1;
    check("midrst_sdio_released", SDIO, 1);
    check("midrst_txready", TxReady, 1);
    check("midrst_busy", Busy, 0);
    CSn = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_rxvalid", rxv_cnt - c0, 0);
    check("midrst_busy_after", Busy, 0);

`ifdef SPI_SLAVE_STATUS_EN
    check("status_cleared_by_rst", TxUnderrun, 0);
    load_word(8'hB4);
    frame_begin(1'b1, 1'b1);
    shift_bits(16, 16'h0000, got);
    frame_end();
    check("underrun_stream", got, 16'hB400);
    check("underrun_flag", TxUnderrun, 1);
    check("underrun_no_frameerr", FrameErr, 0);
    repeat (10) @(negedge clk);
    check("underrun_sticky", TxUnderrun, 1);
    StatusClr = 1'b1;
    @(negedge clk);
    StatusClr = 1'b0;
    @(negedge clk);
    check("underrun_cleared", TxUnderrun, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
